// File: rtl/ieee1355_pkg.sv
// Shared constants and types for the IEEE1355 DS-link receiver.
package ieee1355_pkg;

    localparam int C_CHAR_BITS = 10;
    localparam int C_DATA_BITS = 8;
    localparam logic [C_CHAR_BITS-1:0] C_NULL_CHAR = 10'b1111000110;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } rx_state_t;

endpackage

// File: rtl/ieee1355_ds_sync.sv
// Two-flop synchronizer plus history flop for the D and S lines; flags a change on either line.
module ieee1355_ds_sync
    import ieee1355_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    input  logic s_in,
    output logic d_s2,
    output logic d_edge,
    output logic s_edge
);

    // Bit 0 is the first synchronizer stage, bit 2 the history flop.
    logic [2:0] dPipe_q;
    logic [2:0] sPipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dPipe_q <= '0;
            sPipe_q <= '0;
        end else begin
            dPipe_q <= {dPipe_q[1:0], d_in};
            sPipe_q <= {sPipe_q[1:0], s_in};
        end
    end

    assign d_s2   = dPipe_q[1];
    assign d_edge = dPipe_q[1] ^ dPipe_q[2];
    assign s_edge = sPipe_q[1] ^ sPipe_q[2];

endmodule

// File: rtl/ieee1355_ds_rx.sv
// IEEE1355 DS-link receiver: bit recovery, NULL alignment, byte output with backpressure.
// Define IEEE1355_RX_NULL_COUNT_EN to add the null_count output.
module ieee1355_ds_rx
    import ieee1355_pkg::*;
#(
    parameter int G_TIMEOUT_CYCLES = 64,
    parameter int G_CHAR_BITS      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d_in,
    input  logic                   s_in,
    output logic [C_DATA_BITS-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   rx_synced,
    output logic                   rx_overrun,
    input  logic                   overrun_clr,
    output logic                   rx_timeout,
    output logic                   rx_ds_err
`ifdef IEEE1355_RX_NULL_COUNT_EN
    ,
    output logic [15:0]            null_count
`endif
);

    localparam int TO_W = $clog2(G_TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(G_TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_FIRE = TO_W'(G_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      BIT_LAST = 4'(G_CHAR_BITS - 1);

    logic                   dS2;
    logic                   dEdge;
    logic                   sEdge;
    logic                   bitStrobe;
    logic                   anyEdge;
    logic [C_CHAR_BITS-1:0] shifted;

    rx_state_t              state_q, state_d;
    logic [C_CHAR_BITS-1:0] shifter_q, shifter_d;
    logic [C_CHAR_BITS-1:0] charWord_q, charWord_d;
    logic                   charDone_q, charDone_d;
    logic [3:0]             bitCnt_q, bitCnt_d;
    logic [TO_W-1:0]        toCnt_q, toCnt_d;
    logic [C_DATA_BITS-1:0] rxData_q, rxData_d;
    logic                   rxValid_q, rxValid_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic                   dsErr_q, dsErr_d;

    ieee1355_ds_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_in   (d_in),
        .s_in   (s_in),
        .d_s2   (dS2),
        .d_edge (dEdge),
        .s_edge (sEdge)
    );

    assign bitStrobe = dEdge ^ sEdge;
    assign anyEdge   = dEdge | sEdge;
    assign shifted   = {dS2, shifter_q[C_CHAR_BITS-1:1]};

    // The shifter runs in every state so a NULL seen in HUNT aligns on its last bit.
    always_comb begin
        state_d    = state_q;
        shifter_d  = shifter_q;
        bitCnt_d   = bitCnt_q;
        charWord_d = charWord_q;
        charDone_d = 1'b0;
        timeout_d  = 1'b0;
        dsErr_d    = 1'b0;
        toCnt_d    = toCnt_q;

        if (anyEdge) begin
            toCnt_d = '0;
        end else if (toCnt_q != TO_MAX) begin
            toCnt_d = toCnt_q + 1'b1;
        end

        if (bitStrobe) begin
            shifter_d = shifted;
        end

        case (state_q)
            HUNT: begin
                if (bitStrobe && (shifted == C_NULL_CHAR)) begin
                    state_d  = SYNCED;
                    bitCnt_d = '0;
                end
            end
            SYNCED: begin
                if (bitStrobe) begin
                    if (bitCnt_q == BIT_LAST) begin
                        bitCnt_d   = '0;
                        charDone_d = 1'b1;
                        charWord_d = shifted;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (dEdge && sEdge) begin
            dsErr_d  = 1'b1;
            state_d  = HUNT;
            bitCnt_d = '0;
        end else if ((state_q == SYNCED) && !anyEdge && (toCnt_q == TO_FIRE)) begin
            timeout_d = 1'b1;
            state_d   = HUNT;
            bitCnt_d  = '0;
        end
    end

    // A completed char is evaluated one cycle after its last shift; overrun set beats clear.
    always_comb begin
        rxData_d  = rxData_q;
        rxValid_d = rxValid_q;
        overrun_d = overrun_q;

        if (rxValid_q && rx_ready) begin
            rxValid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (charDone_q && (charWord_q != C_NULL_CHAR)) begin
            if (rxValid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rxData_d  = charWord_q[C_DATA_BITS-1:0];
                rxValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            shifter_q  <= '0;
            charWord_q <= '0;
            charDone_q <= 1'b0;
            bitCnt_q   <= '0;
            toCnt_q    <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            dsErr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shifter_q  <= shifter_d;
            charWord_q <= charWord_d;
            charDone_q <= charDone_d;
            bitCnt_q   <= bitCnt_d;
            toCnt_q    <= toCnt_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            dsErr_q    <= dsErr_d;
        end
    end

`ifdef IEEE1355_RX_NULL_COUNT_EN
    logic [15:0] nullCnt_q, nullCnt_d;
    logic        nullAlign;
    logic        nullEval;

    // Both the aligning NULL and every NULL evaluated while synced are counted.
    assign nullAlign = (state_q == HUNT) && bitStrobe && (shifted == C_NULL_CHAR);
    assign nullEval  = charDone_q && (charWord_q == C_NULL_CHAR);

    always_comb begin
        nullCnt_d = nullCnt_q + 16'(nullAlign) + 16'(nullEval);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nullCnt_q <= '0;
        end else begin
            nullCnt_q <= nullCnt_d;
        end
    end

    assign null_count = nullCnt_q;
`endif

    assign rx_data    = rxData_q;
    assign rx_valid   = rxValid_q;
    assign rx_synced  = (state_q == SYNCED);
    assign rx_overrun = overrun_q;
    assign rx_timeout = timeout_q;
    assign rx_ds_err  = dsErr_q;

endmodule
